// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory macro port arbiter: FSM encoding,
// requester identifiers, default phase timing and the latched op record.
package mem_port_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PRECH   = 3'd1,
        ST_ACCESS  = 3'd2,
        ST_RECOVER = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    // Requester identifiers, also used as bit positions in gnt/done/win vectors.
    localparam int REQ_CMD = 0;
    localparam int REQ_PST = 1;
    localparam int REQ_SNS = 2;

    // Round-robin pointer values: which of pst/sns wins the next tie.
    localparam logic RR_PST = 1'b0;
    localparam logic RR_SNS = 1'b1;

    // Default phase lengths in clock cycles.
    localparam int T_PC_DEF  = 2;
    localparam int T_ACC_DEF = 3;
    localparam int T_REC_DEF = 1;

    // Access parameters captured from the winning requester at grant time.
    typedef struct packed {
        logic        we;
        logic [5:0]  addr;
        logic [2:0]  sel;
        logic [15:0] wdata;
    } op_t;

    // Timer reload value for a phase lasting 'cycles' cycles (counts down to zero).
    function automatic logic [3:0] phase_load(input int cycles);
        phase_load = 4'(cycles - 1);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester handshakes and array macro pins around the arbiter.
// slave: the arbiter's view; master: requesters plus array model view.
interface mem_port_arbiter_if;

    logic        cmd_req,   pst_req,   sns_req;
    logic        cmd_we,    pst_we,    sns_we;
    logic [5:0]  cmd_addr,  pst_addr,  sns_addr;
    logic [2:0]  cmd_sel,   pst_sel,   sns_sel;
    logic [15:0] cmd_wdata, pst_wdata, sns_wdata;
    logic        cmd_gnt,   pst_gnt,   sns_gnt;
    logic        cmd_done,  pst_done,  sns_done;
    logic [15:0] rdata;
    logic        tx_enable;
    logic        busy;
    logic        PC_B;
    logic        WE;
    logic        SE;
    logic [5:0]  mem_address;
    logic [2:0]  mem_sel;
    logic [15:0] mem_data_out;
    logic [15:0] mem_read_in;

    modport slave (
        input  cmd_req, pst_req, sns_req,
        input  cmd_we, pst_we, sns_we,
        input  cmd_addr, pst_addr, sns_addr,
        input  cmd_sel, pst_sel, sns_sel,
        input  cmd_wdata, pst_wdata, sns_wdata,
        output cmd_gnt, pst_gnt, sns_gnt,
        output cmd_done, pst_done, sns_done,
        output rdata,
        input  tx_enable,
        output busy,
        output PC_B, WE, SE,
        output mem_address, mem_sel, mem_data_out,
        input  mem_read_in
    );

    modport master (
        output cmd_req, pst_req, sns_req,
        output cmd_we, pst_we, sns_we,
        output cmd_addr, pst_addr, sns_addr,
        output cmd_sel, pst_sel, sns_sel,
        output cmd_wdata, pst_wdata, sns_wdata,
        input  cmd_gnt, pst_gnt, sns_gnt,
        input  cmd_done, pst_done, sns_done,
        input  rdata,
        output tx_enable,
        input  busy,
        input  PC_B, WE, SE,
        input  mem_address, mem_sel, mem_data_out,
        output mem_read_in
    );

endinterface

// File: rtl/mem_port_arbiter_rr_select.sv
// Combinational requester picker: cmd has fixed priority, pst and sns share
// the remaining slot round-robin. sns is only eligible while not backscattering.
module mem_port_rr_select
    import mem_port_pkg::*;
(
    input  logic [2:0] req,
    input  logic       tx_enable,
    input  logic       ptr,
    output logic [2:0] win,
    output logic       valid
);

    logic sns_ok_s;

    assign sns_ok_s = req[REQ_SNS] & ~tx_enable;
    assign valid    = req[REQ_CMD] | req[REQ_PST] | sns_ok_s;

    // One-hot winner selection.
    always_comb begin
        win = 3'b000;
        if (req[REQ_CMD]) begin
            win[REQ_CMD] = 1'b1;
        end else if (req[REQ_PST] && sns_ok_s) begin
            if (ptr == RR_PST) begin
                win[REQ_PST] = 1'b1;
            end else begin
                win[REQ_SNS] = 1'b1;
            end
        end else if (req[REQ_PST]) begin
            win[REQ_PST] = 1'b1;
        end else if (sns_ok_s) begin
            win[REQ_SNS] = 1'b1;
        end else begin
            win = 3'b000;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port owner of the memory macro: arbitrates cmd/pst/sns and walks each
// granted access through precharge, access and recovery with one shared timer.
// All outputs are registered; they are computed from the next FSM state.
module mem_port_arbiter
    import mem_port_pkg::*;
#(
    parameter int T_PC  = T_PC_DEF,
    parameter int T_ACC = T_ACC_DEF,
    parameter int T_REC = T_REC_DEF
)(
    input  logic              clk,
    input  logic              reset,
    mem_port_arbiter_if.slave bus
);

    state_t      state_r, state_n;
    logic [3:0]  timer_r, timer_n;
    op_t         op_r, op_n;
    op_t         cand_s;
    logic [2:0]  owner_r, owner_n;
    logic        ptr_r, ptr_n;
    logic [2:0]  req_s, win_s;
    logic        valid_s, grant_s, drive_s, capture_s;

    logic [2:0]  gnt_r, gnt_n;
    logic [2:0]  done_r, done_n;
    logic        busy_r, busy_n;
    logic        pc_b_r, pc_b_n;
    logic        we_r, we_n;
    logic        se_r, se_n;
    logic [5:0]  addr_r, addr_n;
    logic [2:0]  sel_r, sel_n;
    logic [15:0] dout_r, dout_n;
    logic [15:0] rdata_r, rdata_n;

    assign req_s = {bus.sns_req, bus.pst_req, bus.cmd_req};

    mem_port_rr_select u_rr_select (
        .req       (req_s),
        .tx_enable (bus.tx_enable),
        .ptr       (ptr_r),
        .win       (win_s),
        .valid     (valid_s)
    );

    // Fields of the requester that would win this cycle.
    always_comb begin
        cand_s = '0;
        if (win_s[REQ_CMD]) begin
            cand_s = {bus.cmd_we, bus.cmd_addr, bus.cmd_sel, bus.cmd_wdata};
        end else if (win_s[REQ_PST]) begin
            cand_s = {bus.pst_we, bus.pst_addr, bus.pst_sel, bus.pst_wdata};
        end else begin
            cand_s = {bus.sns_we, bus.sns_addr, bus.sns_sel, bus.sns_wdata};
        end
    end

    // Next-state, phase timer, grant decision and op latch.
    always_comb begin
        state_n = state_r;
        timer_n = timer_r;
        op_n    = op_r;
        owner_n = owner_r;
        ptr_n   = ptr_r;
        gnt_n   = 3'b000;
        grant_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                // A grant issued last cycle starts precharge now.
                if (gnt_r != 3'b000) begin
                    state_n = ST_PRECH;
                    timer_n = phase_load(T_PC);
                end else if (valid_s) begin
                    grant_s = 1'b1;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_PRECH: begin
                if (timer_r == 4'd0) begin
                    state_n = ST_ACCESS;
                    timer_n = phase_load(T_ACC);
                end else begin
                    timer_n = timer_r - 4'd1;
                end
            end
            ST_ACCESS: begin
                if (timer_r == 4'd0) begin
                    state_n = ST_RECOVER;
                    timer_n = phase_load(T_REC);
                end else begin
                    timer_n = timer_r - 4'd1;
                end
            end
            ST_RECOVER: begin
                if (timer_r == 4'd0) begin
                    state_n = ST_DONE;
                    timer_n = 4'd0;
                end else begin
                    timer_n = timer_r - 4'd1;
                end
            end
            ST_DONE: begin
                // Evaluating here lets the next grant land the cycle after done.
                state_n = ST_IDLE;
                timer_n = 4'd0;
                if (valid_s) begin
                    grant_s = 1'b1;
                end else begin
                    grant_s = 1'b0;
                end
            end
            default: begin
                state_n = ST_IDLE;
                timer_n = 4'd0;
            end
        endcase

        if (grant_s) begin
            gnt_n   = win_s;
            owner_n = win_s;
            op_n    = cand_s;
            if (win_s[REQ_PST]) begin
                ptr_n = RR_SNS;
            end else if (win_s[REQ_SNS]) begin
                ptr_n = RR_PST;
            end else begin
                ptr_n = ptr_r;
            end
        end else begin
            gnt_n = 3'b000;
        end
    end

    // Registered output values derived from the upcoming state.
    always_comb begin
        busy_n    = (state_n != ST_IDLE) || grant_s;
        pc_b_n    = (state_n != ST_PRECH);
        we_n      = (state_n == ST_ACCESS) && op_r.we;
        se_n      = (state_n == ST_ACCESS) && !op_r.we;
        drive_s   = (state_n == ST_PRECH) || (state_n == ST_ACCESS) || (state_n == ST_RECOVER);
        capture_s = (state_r == ST_ACCESS) && (timer_r == 4'd0) && !op_r.we;
        if (state_n == ST_DONE) begin
            done_n = owner_r;
        end else begin
            done_n = 3'b000;
        end
        if (drive_s) begin
            addr_n = op_r.addr;
            sel_n  = op_r.sel;
            dout_n = op_r.wdata;
        end else begin
            addr_n = 6'd0;
            sel_n  = 3'd0;
            dout_n = 16'd0;
        end
        if (capture_s) begin
            rdata_n = bus.mem_read_in;
        end else begin
            rdata_n = rdata_r;
        end
    end

    // FSM state, phase timer, op register, owner and round-robin pointer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
            timer_r <= 4'd0;
            op_r    <= '0;
            owner_r <= 3'b000;
            ptr_r   <= RR_PST;
        end else begin
            state_r <= state_n;
            timer_r <= timer_n;
            op_r    <= op_n;
            owner_r <= owner_n;
            ptr_r   <= ptr_n;
        end
    end

    // Output registers; reset drops every strobe in the same instant.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gnt_r   <= 3'b000;
            done_r  <= 3'b000;
            busy_r  <= 1'b0;
            pc_b_r  <= 1'b1;
            we_r    <= 1'b0;
            se_r    <= 1'b0;
            addr_r  <= 6'd0;
            sel_r   <= 3'd0;
            dout_r  <= 16'd0;
            rdata_r <= 16'd0;
        end else begin
            gnt_r   <= gnt_n;
            done_r  <= done_n;
            busy_r  <= busy_n;
            pc_b_r  <= pc_b_n;
            we_r    <= we_n;
            se_r    <= se_n;
            addr_r  <= addr_n;
            sel_r   <= sel_n;
            dout_r  <= dout_n;
            rdata_r <= rdata_n;
        end
    end

    assign bus.cmd_gnt      = gnt_r[REQ_CMD];
    assign bus.pst_gnt      = gnt_r[REQ_PST];
    assign bus.sns_gnt      = gnt_r[REQ_SNS];
    assign bus.cmd_done     = done_r[REQ_CMD];
    assign bus.pst_done     = done_r[REQ_PST];
    assign bus.sns_done     = done_r[REQ_SNS];
    assign bus.busy         = busy_r;
    assign bus.PC_B         = pc_b_r;
    assign bus.WE           = we_r;
    assign bus.SE           = se_r;
    assign bus.mem_address  = addr_r;
    assign bus.mem_sel      = sel_r;
    assign bus.mem_data_out = dout_r;
    assign bus.rdata        = rdata_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: expected accesses are queued in grant
// order as stimulus is driven; a negedge monitor pops one per grant and checks
// every phase of the access against fixed cycle offsets from the grant.
module tb_mem_port_arbiter;
    import mem_port_pkg::*;

    localparam int TPC  = 2;
    localparam int TACC = 3;
    localparam int TREC = 1;
    localparam int LAT  = 1 + TPC + TACC + TREC + 1;

    typedef struct {
        int          id;
        logic        we;
        logic [5:0]  addr;
        logic [2:0]  sel;
        logic [15:0] wdata;
        logic [15:0] rdata;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  req_v = 3'b000;
    logic        we_v [3];
    logic [5:0]  addr_v [3];
    logic [2:0]  sel_v [3];
    logic [15:0] wdata_v [3];
    logic        tx_v = 1'b0;
    logic [2:0]  gnt_v, done_v;

    int          n_tests = 0;
    int          n_fail  = 0;
    exp_t        sb_q[$];
    int          gnt_cyc_q[$];
    bit          active = 1'b0;
    int          k = 0;
    int          cyc = 0;
    exp_t        cur;

    logic [15:0] array_mem [64];
    logic [63:0] written = '0;
    logic [15:0] shadow_mem [64];

    always #5 clk = ~clk;

    mem_port_arbiter_if bus ();

    mem_port_arbiter dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus)
    );

    assign bus.cmd_req   = req_v[0];
    assign bus.pst_req   = req_v[1];
    assign bus.sns_req   = req_v[2];
    assign bus.cmd_we    = we_v[0];
    assign bus.pst_we    = we_v[1];
    assign bus.sns_we    = we_v[2];
    assign bus.cmd_addr  = addr_v[0];
    assign bus.pst_addr  = addr_v[1];
    assign bus.sns_addr  = addr_v[2];
    assign bus.cmd_sel   = sel_v[0];
    assign bus.pst_sel   = sel_v[1];
    assign bus.sns_sel   = sel_v[2];
    assign bus.cmd_wdata = wdata_v[0];
    assign bus.pst_wdata = wdata_v[1];
    assign bus.sns_wdata = wdata_v[2];
    assign bus.tx_enable = tx_v;
    assign gnt_v  = {bus.sns_gnt, bus.pst_gnt, bus.cmd_gnt};
    assign done_v = {bus.sns_done, bus.pst_done, bus.cmd_done};

    function automatic logic [15:0] init_val(input logic [5:0] a);
        init_val = (a == 6'h10) ? 16'h1234 : {10'h2C5, a};
    endfunction

    // Array model: sense data only while SE is high, otherwise a poison pattern.
    assign bus.mem_read_in = bus.SE ? (written[bus.mem_address] ? array_mem[bus.mem_address]
                                                                : init_val(bus.mem_address))
                                    : 16'hDEAD;

    // Array model write port.
    always @(negedge clk) begin
        if (bus.WE) begin
            array_mem[bus.mem_address] = bus.mem_data_out;
            written[bus.mem_address]   = 1'b1;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Monitor: one scoreboard entry per grant, phase checks keyed on cycles since grant.
    always @(negedge clk) begin
        bit acc;
        cyc++;
        if (rst) begin
            active = 1'b0;
        end else begin
            check_eq("gnt_onehot", 32'($countones(gnt_v) <= 1), 32'd1);
            if (gnt_v != 3'b000) begin
                check_eq("gnt_overlap", 32'(active), 32'd0);
                gnt_cyc_q.push_back(cyc);
                if (sb_q.size() == 0) begin
                    check_eq("gnt_unexpected", 32'(gnt_v), 32'd0);
                    active = 1'b0;
                end else begin
                    cur = sb_q.pop_front();
                    check_eq("gnt_who", 32'(gnt_v), 32'(1) << cur.id);
                    check_eq("gnt_busy", 32'(bus.busy), 32'd1);
                    check_eq("gnt_pcb", 32'(bus.PC_B), 32'd1);
                    check_eq("gnt_strobe", 32'({bus.WE, bus.SE}), 32'd0);
                    check_eq("gnt_done", 32'(done_v), 32'd0);
                    active = 1'b1;
                    k = 0;
                end
            end else if (active) begin
                k++;
                acc = (k >= TPC + 1) && (k <= TPC + TACC);
                check_eq("busy", 32'(bus.busy), 32'd1);
                check_eq("pc_b", 32'(bus.PC_B), (k >= 1 && k <= TPC) ? 32'd0 : 32'd1);
                check_eq("we", 32'(bus.WE), 32'(acc && cur.we));
                check_eq("se", 32'(bus.SE), 32'(acc && !cur.we));
                if (k <= TPC + TACC + TREC) begin
                    check_eq("mem_address", 32'(bus.mem_address), 32'(cur.addr));
                    check_eq("mem_sel", 32'(bus.mem_sel), 32'(cur.sel));
                    check_eq("mem_data_out", 32'(bus.mem_data_out), 32'(cur.wdata));
                end
                check_eq("done", 32'(done_v), (k == LAT - 1) ? (32'(1) << cur.id) : 32'd0);
                if (k == LAT - 1) begin
                    if (!cur.we) begin
                        check_eq("rdata", 32'(bus.rdata), 32'(cur.rdata));
                    end
                    active = 1'b0;
                end
            end else begin
                check_eq("idle_busy", 32'(bus.busy), 32'd0);
                check_eq("idle_strobes", 32'({bus.PC_B, bus.WE, bus.SE}), 32'b100);
                check_eq("idle_done", 32'(done_v), 32'd0);
            end
        end
    end

    task automatic step(input bit hold);
        @(negedge clk);
        if (!hold) begin
            for (int i = 0; i < 3; i++) begin
                if (gnt_v[i]) req_v[i] = 1'b0;
            end
        end
    endtask

    task automatic push_exp(input int id, input logic we, input logic [5:0] a,
                            input logic [2:0] s, input logic [15:0] d);
        exp_t e;
        e.id = id; e.we = we; e.addr = a; e.sel = s; e.wdata = d;
        e.rdata = we ? 16'h0000 : shadow_mem[a];
        if (we) shadow_mem[a] = d;
        sb_q.push_back(e);
    endtask

    task automatic drive_req(input int id, input logic we, input logic [5:0] a,
                             input logic [2:0] s, input logic [15:0] d);
        we_v[id] = we; addr_v[id] = a; sel_v[id] = s; wdata_v[id] = d;
        req_v[id] = 1'b1;
    endtask

    task automatic issue(input int id, input logic we, input logic [5:0] a,
                         input logic [2:0] s, input logic [15:0] d);
        push_exp(id, we, a, s, d);
        drive_req(id, we, a, s, d);
    endtask

    task automatic wait_gnt(input int id, input int budget);
        int n = 0;
        while (n < budget && !gnt_v[id]) begin
            step(1'b0);
            n++;
        end
        check_eq("wait_gnt", 32'(gnt_v[id]), 32'd1);
    endtask

    task automatic run_until_idle(input int budget);
        int n = 0;
        bit drained;
        drained = 1'b0;
        while (n < budget && !drained) begin
            step(1'b0);
            n++;
            drained = (sb_q.size() == 0) && !active && (req_v == 3'b000) && !bus.busy;
        end
        check_eq("drain", 32'(drained), 32'd1);
    endtask

    initial begin
        int n0;
        int grants;
        for (int i = 0; i < 64; i++) shadow_mem[i] = init_val(6'(i));
        for (int i = 0; i < 3; i++) begin
            we_v[i] = 1'b0; addr_v[i] = 6'd0; sel_v[i] = 3'd0; wdata_v[i] = 16'd0;
        end

        // Reset state.
        repeat (3) step(1'b0);
        check_eq("rst_strobes", 32'({bus.PC_B, bus.WE, bus.SE}), 32'b100);
        check_eq("rst_addr", 32'({bus.mem_address, bus.mem_sel}), 32'd0);
        check_eq("rst_dout", 32'(bus.mem_data_out), 32'd0);
        check_eq("rst_rdata", 32'(bus.rdata), 32'd0);
        check_eq("rst_busy", 32'(bus.busy), 32'd0);
        check_eq("rst_gnt_done", 32'({gnt_v, done_v}), 32'd0);
        rst = 1'b0;
        repeat (2) step(1'b0);

        // cmd write; fields scrambled after grant must not leak to the array.
        issue(REQ_CMD, 1'b1, 6'h05, 3'd1, 16'hA5C3);
        wait_gnt(REQ_CMD, 10);
        addr_v[0] = 6'h3F; wdata_v[0] = 16'hFFFF; sel_v[0] = 3'd7;
        run_until_idle(30);

        // cmd read of a preloaded word.
        issue(REQ_CMD, 1'b0, 6'h10, 3'd2, 16'h0000);
        run_until_idle(30);

        // All three at once: cmd, then pst, then sns; pst reads what cmd wrote.
        n0 = gnt_cyc_q.size();
        push_exp(REQ_CMD, 1'b1, 6'h02, 3'd3, 16'h1111);
        push_exp(REQ_PST, 1'b0, 6'h02, 3'd3, 16'h0000);
        push_exp(REQ_SNS, 1'b1, 6'h03, 3'd4, 16'h3333);
        drive_req(REQ_CMD, 1'b1, 6'h02, 3'd3, 16'h1111);
        drive_req(REQ_PST, 1'b0, 6'h02, 3'd3, 16'h0000);
        drive_req(REQ_SNS, 1'b1, 6'h03, 3'd4, 16'h3333);
        run_until_idle(60);
        check_eq("gnt_count3", 32'(gnt_cyc_q.size() - n0), 32'd3);
        if (gnt_cyc_q.size() - n0 == 3) begin
            check_eq("spacing1", 32'(gnt_cyc_q[n0 + 1] - gnt_cyc_q[n0]), 32'(LAT));
            check_eq("spacing2", 32'(gnt_cyc_q[n0 + 2] - gnt_cyc_q[n0 + 1]), 32'(LAT));
        end

        // sns blocked by tx_enable, then granted the cycle after it falls.
        tx_v = 1'b1;
        drive_req(REQ_SNS, 1'b0, 6'h03, 3'd5, 16'h0000);
        repeat (20) step(1'b1);
        check_eq("sns_blocked", 32'(gnt_v), 32'd0);
        push_exp(REQ_SNS, 1'b0, 6'h03, 3'd5, 16'h0000);
        tx_v = 1'b0;
        step(1'b0);
        check_eq("sns_gnt_after_tx", 32'(gnt_v[REQ_SNS]), 32'd1);
        // tx_enable rising mid-access must not abort it.
        step(1'b0);
        tx_v = 1'b1;
        run_until_idle(30);
        tx_v = 1'b0;

        // pst and sns held continuously: strict alternation.
        push_exp(REQ_PST, 1'b1, 6'h08, 3'd6, 16'h8888);
        push_exp(REQ_SNS, 1'b0, 6'h08, 3'd6, 16'h0000);
        push_exp(REQ_PST, 1'b1, 6'h08, 3'd6, 16'h8888);
        push_exp(REQ_SNS, 1'b0, 6'h08, 3'd6, 16'h0000);
        drive_req(REQ_PST, 1'b1, 6'h08, 3'd6, 16'h8888);
        drive_req(REQ_SNS, 1'b0, 6'h08, 3'd6, 16'h0000);
        grants = 0;
        for (int n = 0; n < 60 && grants < 4; n++) begin
            step(1'b1);
            if (gnt_v != 3'b000) grants++;
        end
        req_v = 3'b000;
        check_eq("alt_grants", 32'(grants), 32'd4);
        run_until_idle(30);

        // Reset during the second ACCESS cycle of a write, then a clean retry.
        issue(REQ_PST, 1'b1, 6'h09, 3'd2, 16'h9999);
        wait_gnt(REQ_PST, 10);
        repeat (TPC + 2) step(1'b0);
        check_eq("pre_rst_we", 32'(bus.WE), 32'd1);
        rst = 1'b1;
        #1;
        check_eq("mid_rst_we", 32'(bus.WE), 32'd0);
        check_eq("mid_rst_pcb", 32'(bus.PC_B), 32'd1);
        check_eq("mid_rst_busy", 32'(bus.busy), 32'd0);
        check_eq("mid_rst_done", 32'(done_v), 32'd0);
        repeat (2) step(1'b0);
        rst = 1'b0;
        repeat (3) step(1'b0);
        n0 = gnt_cyc_q.size();
        issue(REQ_PST, 1'b1, 6'h09, 3'd2, 16'h9999);
        run_until_idle(30);
        check_eq("retry_gnt", 32'(gnt_cyc_q.size() - n0), 32'd1);

        // Read back the retried write through cmd.
        issue(REQ_CMD, 1'b0, 6'h09, 3'd0, 16'h0000);
        run_until_idle(30);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Owns the single macro port of the tag's non-volatile/SRAM array (PC_B, WE, SE, mem_address, mem_sel, mem_data_out, mem_read_in).
- Arbitrates between three requesters: reader-command datapath (cmd), always-on flag/counter persistence (pst) and ADC sensor logger (sns).
- Sequences every granted access through precharge → access → recover.
- Sits between the mem controller logic and the array pins; one access in flight at a time.

Parameters:
- T_PC, 2, precharge cycles (PC_B low), legal 1-15.
- T_ACC, 3, access cycles (WE or SE high), legal 1-15.
- T_REC, 1, recovery cycles (all strobes idle) before done, legal 1-15.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- cmd_req / pst_req / sns_req  in  1 each  access request; held high until matching gnt.
- cmd_we / pst_we / sns_we  in  1 each  1 = write, 0 = read.
- cmd_addr / pst_addr / sns_addr  in  6 each  word line address.
- cmd_sel / pst_sel / sns_sel  in  3 each  bank/array select.
- cmd_wdata / pst_wdata / sns_wdata  in  16 each  write data.
- cmd_gnt / pst_gnt / sns_gnt  out  1 each  one-cycle accept pulse.
- cmd_done / pst_done / sns_done  out  1 each  one-cycle completion pulse.
- rdata  out  16  read data; valid in the done cycle, held until the next read capture.
- tx_enable  in  1  backscatter active; blocks sns grants.
- busy  out  1  high from grant cycle through done cycle.
- PC_B  out  1  precharge, active low.
- WE  out  1  write strobe.
- SE  out  1  sense-amp enable.
- mem_address  out  6  word line address.
- mem_sel  out  3  array select.
- mem_data_out  out  16  write data to array.
- mem_read_in  in  16  read data from array.

Behaviour:
- Reset (async, immediate):
  - State IDLE; PC_B=1, WE=0, SE=0.
  - mem_address=0, mem_sel=0, mem_data_out=0, rdata=0.
  - All gnt/done=0, busy=0, round-robin pointer → pst.
- Reset mid-access: the strobes drop in the same instant. No done is issued and the request is lost; the requester must re-request.
- FSM states: IDLE → PRECH → ACCESS → RECOVER → DONE → IDLE.
- IDLE:
  - Evaluate requests each cycle. cmd_req has fixed top priority.
  - Otherwise pst and sns compete round-robin. The pointer flips to the other requester after each pst/sns grant. With only one eligible, that one wins.
  - sns is eligible only when tx_enable=0.
  - On a win: assert that requester's gnt for 1 cycle, latch we/addr/sel/wdata into the internal op register, set busy, go to PRECH next cycle.
- PRECH: PC_B=0 for exactly T_PC cycles. mem_address, mem_sel and mem_data_out are driven from the op register from PRECH entry to the end of RECOVER.
- ACCESS: PC_B=1; WE=1 (write) or SE=1 (read) for exactly T_ACC cycles. WE and SE are never high together, and neither is high while PC_B=0.
- Read capture: rdata <= mem_read_in on the last ACCESS cycle.
- RECOVER: strobes idle (PC_B=1, WE=0, SE=0) for T_REC cycles.
- DONE: the granted requester's done pulses 1 cycle; busy drops next cycle; return to IDLE.
- Latency, gnt cycle to done cycle inclusive: 1+T_PC+T_ACC+T_REC+1 = 8 cycles at defaults. Back-to-back grant possible the cycle after done (throughput 8 cycles per access at defaults).
- Requests arriving while busy wait; no queueing beyond the req level. Dropping req before gnt is harmless.
- Requester field changes after gnt are ignored (fields are latched).
- tx_enable rising during an sns access does not abort it; it only blocks new sns grants.
- Simultaneous cmd+pst+sns in IDLE: cmd first, then pst or sns per pointer.
- Only one gnt and one done may ever be high in any cycle. A single counter (4 bits) times all phases and reloads on each state change.

Decomposition:
- Shared package mem_port_pkg:
  - state encoding (IDLE, PRECH, ACCESS, RECOVER, DONE, 3-bit);
  - requester ID constants (REQ_CMD=0, REQ_PST=1, REQ_SNS=2);
  - default timing constants.
- One sub-module mem_port_rr_select: combinational priority/round-robin picker. Inputs are three req bits, tx_enable and the pointer; outputs are a one-hot winner and a valid flag.
- The FSM, timer and op register stay in mem_port_arbiter.

Test Plan:
- cmd write, addr=6'h05, sel=3'd1, wdata=16'hA5C3 → cmd_gnt at t0; PC_B=0 at t1-t2; WE=1 at t3-t5 with mem_address=5, mem_data_out=A5C3; cmd_done at t7.
- cmd read, addr=6'h10, array returns 16'h1234 during SE → SE=1 for 3 cycles, rdata=1234 in the cmd_done cycle, WE never high.
- cmd, pst and sns all asserted the same cycle, tx_enable=0 → grant order cmd, pst, sns. Each gnt is spaced 8 cycles apart; no overlapping done pulses.
- sns_req held with tx_enable=1 for 20 cycles, pst idle → no sns_gnt. tx_enable falls → sns_gnt on the next cycle.
- pst and sns both held continuously → grants alternate pst, sns, pst, sns; neither wins twice in a row.
- reset asserted during the 2nd ACCESS cycle of a write → WE=0 and PC_B=1 immediately, busy=0, no done. After release, the re-asserted request completes normally in 8 cycles.
